// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing control slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } hz_state_t;

   localparam int                   REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_ZERO  = 5'd0;

   // Enable/flush bundle for PC, fetch register and fetch/execute register.
   typedef struct packed {
      logic pc_en;
      logic fd_en;
      logic fd_flush;
      logic fe_en;
      logic fe_flush;
   } pipe_ctrl_t;

   // Normal advance of every stage.
   localparam pipe_ctrl_t CTRL_RUN      = '{pc_en: 1'b1, fd_en: 1'b1, fd_flush: 1'b0, fe_en: 1'b1, fe_flush: 1'b0};
   // Whole pipe frozen, nothing moves and nothing is squashed.
   localparam pipe_ctrl_t CTRL_FREEZE   = '{pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b0, fe_en: 1'b0, fe_flush: 1'b0};
   // PC moves to the new target while both younger stages load NOP/bubble.
   localparam pipe_ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, fd_en: 1'b1, fd_flush: 1'b1, fe_en: 1'b1, fe_flush: 1'b1};
   // Front end holds, fetch/execute register takes a bubble (all control bits 0).
   localparam pipe_ctrl_t CTRL_BUBBLE   = '{pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b0, fe_en: 1'b1, fe_flush: 1'b1};
   // Value driven while reset is asserted.
   localparam pipe_ctrl_t CTRL_RESET    = '{pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b1, fe_en: 1'b0, fe_flush: 1'b1};

   // True when a source operand is actually read and names the given register.
   function automatic logic reg_match(input logic                 uses,
                                      input logic [REG_IDX_W-1:0] src,
                                      input logic [REG_IDX_W-1:0] dst);
      return uses & (src == dst);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute status in, stage enables/flushes and debug counter out.
// Latency: wires only.
// Backpressure: n/a; mem_busy is carried as a plain freeze request.
interface hazard_ctrl_if #(
   parameter int STALL_CNT_W = 16
);
   import pipeline_pkg::*;

   logic [REG_IDX_W-1:0]   id_read_reg1;
   logic [REG_IDX_W-1:0]   id_read_reg2;
   logic                   id_uses_rs1;
   logic                   id_uses_rs2;
   logic                   id_hlt;
   logic [REG_IDX_W-1:0]   ex_write_reg;
   logic                   ex_reg_write;
   logic                   ex_mem_reg;
   logic                   ex_redirect;
   logic                   mem_busy;
   logic                   pc_en;
   logic                   fd_en;
   logic                   fd_flush;
   logic                   fe_en;
   logic                   fe_flush;
   logic                   halted;
   logic [STALL_CNT_W-1:0] stall_count;

   // Pipeline side: reports stage contents, obeys the controls.
   modport master (
      output id_read_reg1, id_read_reg2, id_uses_rs1, id_uses_rs2, id_hlt,
             ex_write_reg, ex_reg_write, ex_mem_reg, ex_redirect, mem_busy,
      input  pc_en, fd_en, fd_flush, fe_en, fe_flush, halted, stall_count
   );

   // Controller side.
   modport slave (
      input  id_read_reg1, id_read_reg2, id_uses_rs1, id_uses_rs2, id_hlt,
             ex_write_reg, ex_reg_write, ex_mem_reg, ex_redirect, mem_busy,
      output pc_en, fd_en, fd_flush, fe_en, fe_flush, halted, stall_count
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low clear.
// Latency: count reflects an increment one clock after inc.
// Backpressure: none; increments past all-ones are dropped.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on request, stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stall, redirect flush, memory freeze, hlt freeze.
// Latency: controls are combinational from state and current inputs (zero cycles).
// Backpressure: mem_busy freezes all stages (except in HALT, which only drains).
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int STALL_CNT_W  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   hazard_ctrl_if.slave bus
);

   // Redirect itself supplies the first bubble; the counter covers the rest.
   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

   hz_state_t  state, state_nxt;
   logic [3:0] fcnt, fcnt_nxt;
   pipe_ctrl_t ctrl;
   logic       halted_c;
   logic       load_use;
   logic       stall_inc;

   // A load in execute targets a register the decode instruction reads; r0 never hazards.
   assign load_use = bus.ex_mem_reg & bus.ex_reg_write & (bus.ex_write_reg != REG_ZERO) &
                     (reg_match(bus.id_uses_rs1, bus.id_read_reg1, bus.ex_write_reg) |
                      reg_match(bus.id_uses_rs2, bus.id_read_reg2, bus.ex_write_reg));

   // State and remaining-bubble counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // Next state and stage controls; redirect beats hlt/load-use since decode is wrong-path.
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      ctrl      = CTRL_RUN;
      halted_c  = 1'b0;
      if (!rst_n) begin
         ctrl = CTRL_RESET;
      end else begin
         case (state)
            RUN: begin
               if (bus.mem_busy) begin
                  ctrl = CTRL_FREEZE;
               end else if (bus.ex_redirect) begin
                  ctrl = CTRL_REDIRECT;
                  if (FLUSH_CYCLES > 1) begin
                     state_nxt = FLUSH;
                     fcnt_nxt  = FLUSH_RELOAD;
                  end
               end else if (bus.id_hlt) begin
                  ctrl      = CTRL_BUBBLE;
                  state_nxt = HALT;
               end else if (load_use) begin
                  ctrl = CTRL_BUBBLE;
               end
            end
            FLUSH: begin
               if (bus.mem_busy) begin
                  ctrl = CTRL_FREEZE;
               end else begin
                  ctrl = CTRL_REDIRECT;
                  if (bus.ex_redirect) begin
                     fcnt_nxt = FLUSH_RELOAD;
                  end else if (fcnt <= 4'd1) begin
                     state_nxt = RUN;
                     fcnt_nxt  = '0;
                  end else begin
                     fcnt_nxt = fcnt - 4'd1;
                  end
               end
            end
            HALT: begin
               ctrl     = CTRL_BUBBLE;
               halted_c = 1'b1;
            end
            default: begin
               state_nxt = RUN;
               fcnt_nxt  = '0;
            end
         endcase
      end
   end

   // Any RUN/FLUSH cycle where the PC does not advance is a stall.
   assign stall_inc = rst_n & (state != HALT) & ~ctrl.pc_en;

   sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .count (bus.stall_count)
   );

   assign bus.pc_en    = ctrl.pc_en;
   assign bus.fd_en    = ctrl.fd_en;
   assign bus.fd_flush = ctrl.fd_flush;
   assign bus.fe_en    = ctrl.fe_en;
   assign bus.fe_flush = ctrl.fe_flush;
   assign bus.halted   = halted_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus random traffic
// checked every cycle against a behavioural model (bubbles-remaining count, halt flag,
// saturating stall tally).
module tb_hazard_ctrl;

   localparam int FC   = 3;
   localparam int SW   = 4;
   localparam int SMAX = (1 << SW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   hazard_ctrl_if #(.STALL_CNT_W(SW)) bus ();

   hazard_ctrl #(.FLUSH_CYCLES(FC), .STALL_CNT_W(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_rem = 0, m_stall = 0;
   bit m_halt = 0;
   int n_rem = 0, n_stall = 0;
   bit n_halt = 0;

   function automatic bit model_load_use();
      if (!(bus.ex_mem_reg && bus.ex_reg_write) || bus.ex_write_reg == 0) return 0;
      if (bus.id_uses_rs1 && bus.id_read_reg1 == bus.ex_write_reg) return 1;
      if (bus.id_uses_rs2 && bus.id_read_reg2 == bus.ex_write_reg) return 1;
      return 0;
   endfunction

   // Compare process: outputs must match the model in every cycle.
   always @(negedge clk) begin
      bit e_pc, e_fd, e_fdf, e_fe, e_fef, e_h, stall;
      e_pc = 1; e_fd = 1; e_fdf = 0; e_fe = 1; e_fef = 0; e_h = 0; stall = 0;
      n_rem = m_rem; n_halt = m_halt; n_stall = m_stall;
      if (!rst_n) begin
         e_pc = 0; e_fd = 0; e_fdf = 1; e_fe = 0; e_fef = 1;
         n_rem = 0; n_halt = 0; n_stall = 0;
      end else if (m_halt) begin
         e_pc = 0; e_fd = 0; e_fef = 1; e_h = 1;
      end else if (bus.mem_busy) begin
         e_pc = 0; e_fd = 0; e_fe = 0; stall = 1;
      end else if (bus.ex_redirect) begin
         e_fdf = 1; e_fef = 1; n_rem = FC - 1;
      end else if (m_rem > 0) begin
         e_fdf = 1; e_fef = 1; n_rem = m_rem - 1;
      end else if (bus.id_hlt) begin
         e_pc = 0; e_fd = 0; e_fef = 1; n_halt = 1; stall = 1;
      end else if (model_load_use()) begin
         e_pc = 0; e_fd = 0; e_fef = 1; stall = 1;
      end
      if (stall && n_stall < SMAX) n_stall = n_stall + 1;
      chk("pc_en",       32'(bus.pc_en),       32'(e_pc));
      chk("fd_en",       32'(bus.fd_en),       32'(e_fd));
      chk("fd_flush",    32'(bus.fd_flush),    32'(e_fdf));
      chk("fe_en",       32'(bus.fe_en),       32'(e_fe));
      chk("fe_flush",    32'(bus.fe_flush),    32'(e_fef));
      chk("halted",      32'(bus.halted),      32'(e_h));
      chk("stall_count", 32'(bus.stall_count), 32'(m_stall));
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem <= 0; m_halt <= 0; m_stall <= 0;
      end else begin
         m_rem <= n_rem; m_halt <= n_halt; m_stall <= n_stall;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      bus.id_read_reg1 = 5'd0; bus.id_read_reg2 = 5'd0;
      bus.id_uses_rs1  = 1'b0; bus.id_uses_rs2  = 1'b0;
      bus.id_hlt       = 1'b0; bus.ex_write_reg = 5'd0;
      bus.ex_reg_write = 1'b0; bus.ex_mem_reg   = 1'b0;
      bus.ex_redirect  = 1'b0; bus.mem_busy     = 1'b0;
   endtask

   // Advance to just after the next rising edge and return inputs to idle.
   task automatic nxt();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic set_lu(input logic [4:0] rd);
      bus.ex_mem_reg = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_write_reg = rd;
      bus.id_read_reg2 = rd; bus.id_uses_rs2 = 1'b1;
   endtask

   initial begin
      idle();
      #3;
      chk("rst pc_en",    32'(bus.pc_en),       0);
      chk("rst fd_flush", 32'(bus.fd_flush),    1);
      chk("rst fe_flush", 32'(bus.fe_flush),    1);
      chk("rst halted",   32'(bus.halted),      0);
      chk("rst stall",    32'(bus.stall_count), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("run pc_en", 32'(bus.pc_en), 1);
      chk("run fe_en", 32'(bus.fe_en), 1);

      // Load-use on rs2 = x5: exactly one bubble.
      nxt(); set_lu(5'd5); #1;
      chk("lu pc_en",    32'(bus.pc_en),    0);
      chk("lu fe_flush", 32'(bus.fe_flush), 1);
      nxt(); #1;
      chk("lu clears",   32'(bus.pc_en),       1);
      chk("lu stall",    32'(bus.stall_count), 1);
      // Same pattern targeting x0: no stall.
      nxt(); set_lu(5'd0); #1;
      chk("lu x0 pc_en", 32'(bus.pc_en), 1);
      nxt(); #1;
      chk("lu x0 stall", 32'(bus.stall_count), 1);

      // Redirect: three flush cycles; load-use inside them is ignored.
      nxt(); bus.ex_redirect = 1'b1; #1;
      chk("redir c1 flush", 32'(bus.fd_flush), 1);
      chk("redir c1 pc_en", 32'(bus.pc_en),    1);
      for (int i = 2; i <= 3; i++) begin
         nxt(); set_lu(5'd7); #1;
         chk("redir flush", 32'(bus.fd_flush), 1);
         chk("redir pc_en", 32'(bus.pc_en),    1);
      end
      nxt(); #1;
      chk("redir done flush", 32'(bus.fd_flush),    0);
      chk("redir no stall",   32'(bus.stall_count), 1);

      // mem_busy during FLUSH with one bubble remaining.
      nxt(); bus.ex_redirect = 1'b1;
      nxt();
      for (int i = 0; i < 4; i++) begin
         nxt(); bus.mem_busy = 1'b1; #1;
         chk("busy pc_en",    32'(bus.pc_en),    0);
         chk("busy fe_en",    32'(bus.fe_en),    0);
         chk("busy fd_flush", 32'(bus.fd_flush), 0);
      end
      nxt(); #1;
      chk("post busy flush", 32'(bus.fe_flush),    1);
      chk("post busy stall", 32'(bus.stall_count), 5);
      nxt(); #1;
      chk("back to run", 32'(bus.fd_flush), 0);

      // Redirect and hlt together: redirect wins.
      nxt(); bus.ex_redirect = 1'b1; bus.id_hlt = 1'b1; #1;
      chk("redir+hlt pc_en", 32'(bus.pc_en),  1);
      chk("redir+hlt halt",  32'(bus.halted), 0);
      repeat (3) nxt();
      #1;
      chk("no halt", 32'(bus.halted), 0);

      // Saturation.
      for (int i = 0; i < 20; i++) begin
         nxt(); bus.mem_busy = 1'b1;
      end
      nxt(); #1;
      chk("sat stall", 32'(bus.stall_count), SMAX);

      // hlt, then frozen with mem_busy ignored.
      nxt(); bus.id_hlt = 1'b1; #1;
      chk("hlt pc_en",    32'(bus.pc_en),    0);
      chk("hlt fe_flush", 32'(bus.fe_flush), 1);
      for (int i = 0; i < 3; i++) begin
         nxt(); bus.mem_busy = 1'b1; bus.ex_redirect = 1'b1; #1;
         chk("halted",        32'(bus.halted), 1);
         chk("halted pc_en",  32'(bus.pc_en),  0);
         chk("halted fe_en",  32'(bus.fe_en),  1);
      end
      // Asynchronous reset while halted.
      nxt(); rst_n = 1'b0; #1;
      chk("arst halted", 32'(bus.halted),      0);
      chk("arst stall",  32'(bus.stall_count), 0);
      chk("arst flush",  32'(bus.fd_flush),    1);
      nxt(); rst_n = 1'b1; #1;
      chk("arst release pc_en", 32'(bus.pc_en), 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         nxt();
         rst_n            = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         bus.mem_busy     = ($urandom_range(0, 99) < 20);
         bus.ex_redirect  = ($urandom_range(0, 99) < 15);
         bus.id_hlt       = ($urandom_range(0, 99) < 2);
         bus.ex_mem_reg   = ($urandom_range(0, 99) < 50);
         bus.ex_reg_write = ($urandom_range(0, 99) < 70);
         bus.ex_write_reg = 5'($urandom_range(0, 3));
         bus.id_read_reg1 = 5'($urandom_range(0, 3));
         bus.id_read_reg2 = 5'($urandom_range(0, 3));
         bus.id_uses_rs1  = 1'($urandom_range(0, 1));
         bus.id_uses_rs2  = 1'($urandom_range(0, 1));
      end
      nxt(); rst_n = 1'b1;
      repeat (3) nxt();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
